// File: rtl/ecc_hamming_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ecc_hamming_decoder
// Description : SECDED Hamming decoder/corrector. Recomputes the syndrome of
//               a read-back codeword, corrects single-bit errors, flags
//               double-bit errors and keeps saturating error statistics.
//               Two-stage valid/ready pipeline, one word per cycle.
//               Optional build macro ECC_ERR_INJECT_EN adds the inj_mask
//               input for error injection at input acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_hamming_decoder #(
    parameter int DATA_WIDTH    = 32,
    parameter int PARITY_LENGTH = 6,   // needs 2**PARITY_LENGTH >= DATA_WIDTH+PARITY_LENGTH+1
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH+PARITY_LENGTH-1:0] codeword_in,
    input  logic                                odd_even_parity_in,
`ifdef ECC_ERR_INJECT_EN
    input  logic [DATA_WIDTH+PARITY_LENGTH:0]   inj_mask,
`endif
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               d_out,
    output logic                                sec_err,
    output logic                                ded_err,
    output logic [PARITY_LENGTH-1:0]            syndrome_out,
    input  logic                                cnt_clr,
    output logic [CNT_WIDTH-1:0]                sec_cnt,
    output logic [CNT_WIDTH-1:0]                ded_cnt
);

    localparam int          N   = DATA_WIDTH + PARITY_LENGTH;
    localparam logic [31:0] N_U = 32'(N);

    // Hamming position (1-based) holding data bit idx: the idx-th position
    // that is not a power of two.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 1;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    // ------------------------------------------------------------------
    // Input side: optional injection, syndrome and overall check
    // ------------------------------------------------------------------
    logic [N-1:0]             cw_eff;
    logic                     par_eff;
    logic [PARITY_LENGTH-1:0] syn_in;
    logic                     ov_in;

`ifdef ECC_ERR_INJECT_EN
    assign {par_eff, cw_eff} = {odd_even_parity_in, codeword_in} ^ inj_mask;
`else
    assign {par_eff, cw_eff} = {odd_even_parity_in, codeword_in};
`endif

    // Syndrome = XOR of the indices of every set position
    always_comb begin
        syn_in = '0;
        for (int i = 1; i <= N; i++) begin
            if (cw_eff[i-1]) syn_in = syn_in ^ PARITY_LENGTH'(i);
        end
    end

    assign ov_in = ^{par_eff, cw_eff};

    // ------------------------------------------------------------------
    // Handshake: each stage advances when the next is empty or advancing
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_ready;
    logic in_fire;
    logic out_fire;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Stage 1: registered codeword, syndrome and overall check
    // ------------------------------------------------------------------
    logic [N-1:0]             s1_cw;
    logic [PARITY_LENGTH-1:0] s1_syn;
    logic                     s1_ov;

    // Capture an accepted word; stage empties when its word moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_ov    <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_fire) begin
                s1_cw  <= cw_eff;
                s1_syn <= syn_in;
                s1_ov  <= ov_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Classification and correction of the stage-1 word
    // ------------------------------------------------------------------
    logic                  syn_nz;
    logic                  syn_ok;
    logic                  cls_sec;
    logic                  cls_ded;
    logic                  do_flip;
    logic [N-1:0]          flip_mask;
    logic [N-1:0]          corrected;
    logic [DATA_WIDTH-1:0] data_dec;
    logic                  unused_corrected;

    assign syn_nz    = |s1_syn;
    assign syn_ok    = (32'(s1_syn) <= N_U);
    // Odd overall parity with an in-range syndrome is a single error;
    // syndrome 0 then means the overall parity bit itself flipped.
    assign cls_sec   = s1_ov && syn_ok;
    assign cls_ded   = (syn_nz && !s1_ov) || (s1_ov && !syn_ok);
    assign do_flip   = cls_sec && syn_nz;
    assign flip_mask = N'(1) << (s1_syn - PARITY_LENGTH'(1));
    assign corrected = s1_cw ^ (do_flip ? flip_mask : '0);

    // Data bits occupy the non-power-of-two positions in ascending order
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_extract
        localparam int POS = data_pos(g);
        assign data_dec[g] = corrected[POS-1];
    end

    // Parity positions only feed the syndrome, not the returned data
    assign unused_corrected = ^corrected;

    // ------------------------------------------------------------------
    // Stage 2: registered result, held stable while stalled
    // ------------------------------------------------------------------
    // Load a new result whenever the output stage can accept one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            d_out        <= '0;
            sec_err      <= 1'b0;
            ded_err      <= 1'b0;
            syndrome_out <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                d_out        <= data_dec;
                sec_err      <= cls_sec;
                ded_err      <= cls_ded;
                syndrome_out <= s1_syn;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating error statistics, clear wins over increment
    // ------------------------------------------------------------------
    // Count flagged results as they leave the decoder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (out_fire) begin
            if (sec_err && (sec_cnt != '1)) sec_cnt <= sec_cnt + CNT_WIDTH'(1);
            if (ded_err && (ded_cnt != '1)) ded_cnt <= ded_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecc_hamming_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ecc_hamming_decoder
// Description : Self-checking bench for ecc_hamming_decoder. Expected results
//               come from a position-based error model (which bits were
//               flipped) applied to a behavioural encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_hamming_decoder;

    localparam int DW   = 32;
    localparam int PL   = 6;
    localparam int CW   = 2;
    localparam int N    = DW + PL;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  codeword_in = '0;
    logic          odd_even_parity_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] d_out;
    logic          sec_err;
    logic          ded_err;
    logic [PL-1:0] syndrome_out;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] sec_cnt;
    logic [CW-1:0] ded_cnt;
`ifdef ECC_ERR_INJECT_EN
    logic [N:0]    inj_mask = '0;
`endif

    ecc_hamming_decoder #(
        .DATA_WIDTH   (DW),
        .PARITY_LENGTH(PL),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .codeword_in       (codeword_in),
        .odd_even_parity_in(odd_even_parity_in),
`ifdef ECC_ERR_INJECT_EN
        .inj_mask          (inj_mask),
`endif
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .d_out             (d_out),
        .sec_err           (sec_err),
        .ded_err           (ded_err),
        .syndrome_out      (syndrome_out),
        .cnt_clr           (cnt_clr),
        .sec_cnt           (sec_cnt),
        .ded_cnt           (ded_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sec;
        logic          ded;
        logic [PL-1:0] syn;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   sec_m = 0;
    int   ded_m = 0;
    bit   pend_out = 0, pend_sec = 0, pend_ded = 0, pend_clr = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit is_pow2(input int i);
        return (i & (i - 1)) == 0;
    endfunction

    // Returns {overall_parity, codeword}
    function automatic logic [N:0] encode(input logic [DW-1:0] data);
        logic [N:0] w;
        int j;
        bit p;
        w = '0;
        j = 0;
        for (int i = 1; i <= N; i++) begin
            if (!is_pow2(i)) begin
                w[i-1] = data[j];
                j++;
            end
        end
        for (int k = 0; k < PL; k++) begin
            p = 0;
            for (int i = 1; i <= N; i++)
                if (((i >> k) & 1) == 1 && !is_pow2(i)) p ^= w[i-1];
            w[(1 << k) - 1] = p;
        end
        w[N] = ^w[N-1:0];
        return w;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [N:0] w);
        logic [DW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i <= N; i++) begin
            if (!is_pow2(i)) begin
                d[j] = w[i-1];
                j++;
            end
        end
        return d;
    endfunction

    // p[k] = flipped Hamming position (0 means the overall parity bit)
    function automatic res_t predict(input logic [N:0] bad, input int p[3], input int n);
        res_t r;
        int syn;
        logic [N:0] fixed;
        syn = 0;
        for (int k = 0; k < n; k++) syn ^= p[k];
        r.syn = PL'(syn);
        r.sec = 1'b0;
        r.ded = 1'b0;
        fixed = bad;
        if ((n % 2) == 1 && syn <= N) begin
            r.sec = 1'b1;
            if (syn != 0) fixed[syn-1] = ~fixed[syn-1];
        end else if (n != 0) begin
            r.ded = 1'b1;
        end
        r.d = extract(fixed);
        return r;
    endfunction

    task automatic make_word(input int nflip, output logic [N:0] bad, output res_t e);
        logic [DW-1:0] data;
        int p[3];
        bit dup;
        p = '{0, 0, 0};
        data = $urandom;
        bad = encode(data);
        for (int k = 0; k < nflip; k++) begin
            do begin
                p[k] = $urandom_range(0, N);
                dup = 0;
                for (int m = 0; m < k; m++) if (p[m] == p[k]) dup = 1;
            end while (dup);
            if (p[k] == 0) bad[N] = ~bad[N];
            else           bad[p[k]-1] = ~bad[p[k]-1];
        end
        e = predict(bad, p, nflip);
    endtask

    // One clock: drive inputs, sample handshakes and outputs, keep the
    // expectation queue and counter model in step with transfers.
    task automatic cycle(input bit v, input logic [N:0] word, input res_t e, input bit rdy,
                         input bit clr, output bit in_fire, output bit out_fire,
                         output res_t got, output res_t expd, output bit have);
        @(posedge clk);
        #1;
        if (pend_clr) begin
            sec_m = 0;
            ded_m = 0;
        end else if (pend_out) begin
            if (pend_sec && sec_m < CMAX) sec_m++;
            if (pend_ded && ded_m < CMAX) ded_m++;
        end
        in_valid = v;
        {odd_even_parity_in, codeword_in} = word;
        out_ready = rdy;
        cnt_clr = clr;
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        got  = {d_out, sec_err, ded_err, syndrome_out};
        have = 0;
        expd = '0;
        if (out_fire && exp_q.size() > 0) begin
            expd = exp_q.pop_front();
            have = 1;
        end
        if (in_fire) exp_q.push_back(e);
        pend_out = out_fire;
        pend_sec = sec_err;
        pend_ded = ded_err;
        pend_clr = clr;
    endtask

    task automatic model_reset();
        exp_q.delete();
        sec_m = 0;
        ded_m = 0;
        pend_out = 0;
        pend_clr = 0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || d_out !== '0 || sec_err !== 1'b0 ||
            ded_err !== 1'b0 || syndrome_out !== '0 || sec_cnt !== '0 || ded_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ov=%b ir=%b d=%h sec=%b ded=%b syn=%0d cnt=%0d/%0d required ov=0 ir=1 all zero",
                     out_valid, in_ready, d_out, sec_err, ded_err, syndrome_out, sec_cnt, ded_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Send one word on an idle pipeline; return result and measured latency
    task automatic send_one(input logic [N:0] word, input res_t e, output res_t got, output int lat);
        bit fi, fo, hv;
        res_t ex;
        int c;
        got = '0;
        lat = -1;
        c = 0;
        cycle(1, word, e, 1, 0, fi, fo, got, ex, hv);
        while (!fi && c < 10) begin
            cycle(1, word, e, 1, 0, fi, fo, got, ex, hv);
            c++;
        end
        for (int k = 1; k <= 10; k++) begin
            cycle(0, '0, '0, 1, 0, fi, fo, got, ex, hv);
            if (fo) begin
                lat = k;
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic test_directed();
        logic [N:0] w, bad;
        res_t got, ex;
        bit fi, fo, hv;
        int lat;
        res_t req[4];
        int   sec_req[4];
        int   ded_req[4];
        logic [N:0] masks[4];
        w = encode(32'hF000_0000);
        masks[0] = '0;
        masks[1] = '0; masks[1][5] = 1'b1;
        masks[2] = '0; masks[2][N] = 1'b1;
        masks[3] = '0; masks[3][2] = 1'b1; masks[3][9] = 1'b1;
        req[0] = {32'hF000_0000, 1'b0, 1'b0, 6'd0};
        req[1] = {32'hF000_0000, 1'b1, 1'b0, 6'd6};
        req[2] = {32'hF000_0000, 1'b1, 1'b0, 6'd0};
        req[3] = {32'hF000_0021, 1'b0, 1'b1, 6'd9};
        sec_req = '{0, 1, 2, 2};
        ded_req = '{0, 0, 0, 1};
        cycle(0, '0, '0, 1, 1, fi, fo, got, ex, hv);
        for (int t = 0; t < 4; t++) begin
            bad = w ^ masks[t];
            send_one(bad, req[t], got, lat);
            n_cmp++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles required 2", t, lat);
            end
            n_cmp++;
            if (got !== req[t]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: d=%h sec=%b ded=%b syn=%0d required d=%h sec=%b ded=%b syn=%0d",
                         t, got.d, got.sec, got.ded, got.syn, req[t].d, req[t].sec, req[t].ded, req[t].syn);
            end
            cycle(0, '0, '0, 1, 0, fi, fo, got, ex, hv);
            n_cmp++;
            if (sec_cnt !== CW'(sec_req[t]) || ded_cnt !== CW'(ded_req[t])) begin
                n_fail++;
                $display("FAIL directed_counters[%0d]: sec_cnt=%0d ded_cnt=%0d required %0d/%0d",
                         t, sec_cnt, ded_cnt, sec_req[t], ded_req[t]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [N:0] words[4];
        res_t exps[4];
        bit fi, fo, hv;
        res_t got, ex;
        int idx, outs;
        for (int k = 0; k < 4; k++) make_word(k % 2, words[k], exps[k]);
        idx = 0;
        outs = 0;
        for (int c = 0; c < 30 && outs < 4; c++) begin
            cycle(idx < 4, (idx < 4) ? words[idx] : '0, (idx < 4) ? exps[idx] : '0,
                  c >= 3, 0, fi, fo, got, ex, hv);
            if (c == 2) begin
                n_cmp++;
                if (in_ready !== 1'b0 || idx != 2 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL backpressure_hold: in_ready=%b accepted=%0d out_valid=%b required 0/2/1",
                             in_ready, idx, out_valid);
                end
            end
            if (fi) idx++;
            if (fo) begin
                outs++;
                n_cmp++;
                if (!hv || got !== ex) begin
                    n_fail++;
                    $display("FAIL backpressure_order[%0d]: got %h required %h", outs, got, ex);
                end
            end
        end
        in_valid = 0;
        n_cmp++;
        if (outs != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL backpressure_count: emerged %0d required 4", outs);
        end
    endtask

    task automatic test_random();
        logic [N:0] w;
        res_t e, got, ex;
        bit fi, fo, hv;
        make_word($urandom_range(0, 3), w, e);
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 9) < 7, w, e, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 29) == 0, fi, fo, got, ex, hv);
            n_cmp++;
            if (sec_cnt !== CW'(sec_m) || ded_cnt !== CW'(ded_m)) begin
                n_fail++;
                $display("FAIL random_counters[%0d]: sec_cnt=%0d ded_cnt=%0d required %0d/%0d",
                         c, sec_cnt, ded_cnt, sec_m, ded_m);
            end
            if (fo) begin
                n_cmp++;
                if (!hv || got !== ex) begin
                    n_fail++;
                    $display("FAIL random_result[%0d]: got %h required %h", c, got, ex);
                end
            end
            if (fi) make_word($urandom_range(0, 3), w, e);
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            cycle(0, '0, '0, 1, 0, fi, fo, got, ex, hv);
            if (fo) begin
                n_cmp++;
                if (!hv || got !== ex) begin
                    n_fail++;
                    $display("FAIL random_drain: got %h required %h", got, ex);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_lost: %0d words outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        logic [N:0] w;
        res_t e, got, ex;
        bit fi, fo, hv;
        int sent;
        cycle(0, '0, '0, 1, 1, fi, fo, got, ex, hv);
        sent = 0;
        make_word(1, w, e);
        for (int c = 0; c < 30 && (sent < 5 || exp_q.size() > 0); c++) begin
            cycle(sent < 5, w, e, 1, 0, fi, fo, got, ex, hv);
            if (fi) begin
                sent++;
                make_word(1, w, e);
            end
        end
        cycle(0, '0, '0, 1, 0, fi, fo, got, ex, hv);
        n_cmp++;
        if (sec_cnt !== CW'(3) || ded_cnt !== '0) begin
            n_fail++;
            $display("FAIL sec_saturate: sec_cnt=%0d ded_cnt=%0d required 3/0", sec_cnt, ded_cnt);
        end
        cycle(0, '0, '0, 1, 1, fi, fo, got, ex, hv);
        cycle(0, '0, '0, 1, 0, fi, fo, got, ex, hv);
        n_cmp++;
        if (sec_cnt !== '0 || ded_cnt !== '0) begin
            n_fail++;
            $display("FAIL cnt_clear: sec_cnt=%0d ded_cnt=%0d required 0/0", sec_cnt, ded_cnt);
        end
        // Clear in the same cycle as a flagged output transfer
        make_word(1, w, e);
        cycle(1, w, e, 1, 0, fi, fo, got, ex, hv);
        cycle(0, '0, '0, 1, 0, fi, fo, got, ex, hv);
        cycle(0, '0, '0, 1, 1, fi, fo, got, ex, hv);
        n_cmp++;
        if (!fo || got.sec !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_align: out_fire=%b sec=%b required 1/1", fo, got.sec);
        end
        cycle(0, '0, '0, 1, 0, fi, fo, got, ex, hv);
        n_cmp++;
        if (sec_cnt !== '0) begin
            n_fail++;
            $display("FAIL clr_priority: sec_cnt=%0d required 0", sec_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [N:0] w;
        res_t e, got, ex;
        bit fi, fo, hv;
        int lat;
        for (int c = 0; c < 4; c++) begin
            make_word(1, w, e);
            cycle(1, w, e, 0, 0, fi, fo, got, ex, hv);
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: out_valid=%b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || d_out !== '0 || sec_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b d=%h sec_cnt=%0d required 0/1/0/0",
                     out_valid, in_ready, d_out, sec_cnt);
        end
        in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        make_word(0, w, e);
        send_one(w, e, got, lat);
        n_cmp++;
        if (lat != 2 || got !== e) begin
            n_fail++;
            $display("FAIL post_reset_word: lat=%0d got %h required lat=2 %h", lat, got, e);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecc_hamming_decoder.md
Name: ecc_hamming_decoder

Overview:
SECDED Hamming decoder/corrector, directly downstream of ecc_hamming_encoder in the shared-memory ECC path. Consumes the stored codeword plus overall parity bit on memory read-back and recomputes the syndrome. Corrects single-bit errors, flags double-bit errors, and returns the data word. Two-stage pipeline with valid/ready handshakes on both sides, plus saturating error statistics for the BIRA/status logic.

Parameters:
DATA_WIDTH, 32, data word width.
PARITY_LENGTH, 6, Hamming parity bits; must satisfy 2^PARITY_LENGTH >= DATA_WIDTH+PARITY_LENGTH+1.
CNT_WIDTH, 16, width of the saturating error counters.

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  codeword_in/odd_even_parity_in valid.
in_ready  output  1  decoder can accept a word this cycle.
codeword_in  input  DATA_WIDTH+PARITY_LENGTH  codeword as produced by the encoder.
odd_even_parity_in  input  1  overall parity bit from the encoder.
out_valid  output  1  decoded result valid.
out_ready  input  1  consumer accepts result.
d_out  output  DATA_WIDTH  corrected data.
sec_err  output  1  single error detected and corrected; qualified by out_valid.
ded_err  output  1  double error detected, data not corrected; qualified by out_valid.
syndrome_out  output  PARITY_LENGTH  syndrome of the current result.
cnt_clr  input  1  synchronous clear of both counters.
sec_cnt  output  CNT_WIDTH  saturating count of accepted sec_err results.
ded_cnt  output  CNT_WIDTH  saturating count of accepted ded_err results.

Behaviour:
- Codeword layout: codeword_in[i-1] = Hamming position i, i = 1..N, N = DATA_WIDTH+PARITY_LENGTH.
  - Parity bits sit at positions 2^k; data bits fill the remaining positions in ascending order, with d[0] at the lowest.
  - odd_even_parity_in = XOR of all N codeword bits (even overall parity).
- Syndrome: bit k = XOR of all positions i with bit k of i set (parity position included).
- Overall check: ov = XOR(codeword_in, odd_even_parity_in).
- Classification:
  - syn=0, ov=0: clean.
  - syn!=0, ov=1, syn<=N: single error; flip position syn and set sec_err.
  - syn=0, ov=1: error in the overall bit; data untouched, sec_err=1.
  - syn!=0, ov=0: double error; ded_err=1, data passed uncorrected.
  - syn>N, ov=1: ded_err=1 (uncorrectable).
- Pipeline:
  - Stage 1 registers the codeword, syn and ov.
  - Stage 2 registers the corrected data and flags.
  - Latency is 2 cycles from an accepted input to out_valid when unstalled; throughput is 1 word/cycle.
- Handshake:
  - Transfer occurs when valid&&ready.
  - Each stage advances when the stage after it is empty or advancing (standard skid-free pipeline).
  - in_ready = !s1_valid || s1 advancing (combinational from out_ready).
  - out_valid stays asserted and the outputs stay stable until out_ready; no word is dropped or duplicated.
- Counters:
  - Increment on an output transfer with the corresponding flag set.
  - Saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
- Reset:
  - All valids, counters, d_out, syndrome_out and flags go to 0.
  - in_ready = 1 after reset.
  - Reset mid-operation discards in-flight words.

Optional Feature:
ECC_ERR_INJECT_EN.
- Defined: adds input inj_mask (width N+1). The mask is XORed onto {odd_even_parity_in, codeword_in} at input acceptance, before syndrome computation, for self-test and BIRA exercise.
- Undefined: the port is absent and the datapath is unchanged.

Test Plan:
- Encode 0xF0000000 with ecc_hamming_encoder and feed it clean -> after 2 cycles d_out=0xF0000000, sec_err=0, ded_err=0, syndrome_out=0, counters 0.
- Same codeword with codeword_in[5] flipped -> d_out=0xF0000000, sec_err=1, syndrome_out=6, sec_cnt=1.
- Flip only odd_even_parity_in -> d_out correct, sec_err=1, syndrome_out=0.
- Flip bits [2] and [9] -> ded_err=1, sec_err=0, d_out uncorrected, ded_cnt=1.
- Backpressure: stream 4 words with out_ready=0 for 3 cycles -> in_ready drops after 2 words are held; all 4 emerge in order, none lost.
- Saturation and reset:
  - CNT_WIDTH=2, 5 single errors -> sec_cnt=3.
  - cnt_clr -> 0.
  - rst_n low mid-stream -> out_valid=0 immediately.
